// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode encodings used by RTL and bench.
package univ_shift_reg_pkg;

    typedef enum logic [1:0] {
        SR_HOLD = 2'b00,
        SR_SHR  = 2'b01,
        SR_SHL  = 2'b10,
        SR_LOAD = 2'b11
    } sr_mode_e;

endpackage

// File: rtl/univ_shift_reg_shift_frame_cnt.sv
// Shift-frame counter: counts shift cycles, wraps after WIDTH shifts and pulses done on the wrap.
module shift_frame_cnt #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     Resetn,
    input  logic                     shift,
    input  logic                     clear,
    output logic [$clog2(WIDTH)-1:0] cnt,
    output logic                     done
);

    localparam int unsigned     CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (shift) begin
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge Resetn) begin
        if (!Resetn) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign cnt  = cnt_q;
    assign done = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register (hold / shift right / shift left / load) with frame counter.
// Optional registered pattern-match flag enabled by `define PATTERN_MATCH_EN.
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                     clock,
    input  logic                     Resetn,
    input  logic                     en,
    input  logic [1:0]               mode,
    input  logic                     sin_r,
    input  logic                     sin_l,
    input  logic [WIDTH-1:0]         d,
    output logic [WIDTH-1:0]         q,
    output logic                     sout_r,
    output logic                     sout_l,
    output logic [$clog2(WIDTH)-1:0] cnt,
`ifdef PATTERN_MATCH_EN
    output logic                     done,
    input  logic [WIDTH-1:0]         pattern,
    output logic                     match
`else
    output logic                     done
`endif
);

    sr_mode_e         mode_s;
    logic [WIDTH-1:0] q_q, q_d;
    logic             shift, clear;

    assign mode_s = sr_mode_e'(mode);

    always_comb begin
        q_d   = q_q;
        shift = 1'b0;
        clear = 1'b0;
        if (en) begin
            case (mode_s)
                SR_SHR: begin
                    q_d   = {sin_r, q_q[WIDTH-1:1]};
                    shift = 1'b1;
                end
                SR_SHL: begin
                    q_d   = {q_q[WIDTH-2:0], sin_l};
                    shift = 1'b1;
                end
                SR_LOAD: begin
                    q_d   = d;
                    clear = 1'b1;
                end
                default: q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge Resetn) begin
        if (!Resetn) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q      = q_q;
    assign sout_r = q_q[0];
    assign sout_l = q_q[WIDTH-1];

    shift_frame_cnt #(
        .WIDTH (WIDTH)
    ) u_frame_cnt (
        .clock  (clock),
        .Resetn (Resetn),
        .shift  (shift),
        .clear  (clear),
        .cnt    (cnt),
        .done   (done)
    );

`ifdef PATTERN_MATCH_EN
    logic match_q;

    // Compared against next-state so the flag lines up with the q it describes.
    always_ff @(posedge clock or negedge Resetn) begin
        if (!Resetn) begin
            match_q <= 1'b0;
        end else begin
            match_q <= (q_d == pattern);
        end
    end

    assign match = match_q;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg (WIDTH=8, RESET_VAL=0); define PATTERN_MATCH_EN to test match.
module tb_univ_shift_reg;
    import univ_shift_reg_pkg::*;

    typedef struct packed {
        logic [7:0] q;
        logic [2:0] cnt;
        logic       done;
    } exp_t;

    logic       clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = SR_HOLD;
    logic       sin_r = 1'b0;
    logic       sin_l = 1'b0;
    logic [7:0] d = '0;
    logic [7:0] q;
    logic       sout_r, sout_l, done;
    logic [2:0] cnt;
`ifdef PATTERN_MATCH_EN
    logic [7:0] pattern = 8'h9C;
    logic       match;
`endif

    int   n_total = 0;
    int   n_pass  = 0;
    exp_t sb[$];
    event chk_now;

    always #5 clock = ~clock;

    univ_shift_reg #(
        .WIDTH     (8),
        .RESET_VAL (8'h00)
    ) dut (
        .clock   (clock),
        .Resetn  (Resetn),
        .en      (en),
        .mode    (mode),
        .sin_r   (sin_r),
        .sin_l   (sin_l),
        .d       (d),
        .q       (q),
        .sout_r  (sout_r),
        .sout_l  (sout_l),
        .cnt     (cnt),
`ifdef PATTERN_MATCH_EN
        .done    (done),
        .pattern (pattern),
        .match   (match)
`else
        .done    (done)
`endif
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    // Monitor: every clock edge (or an explicit async event) presents a new output to check.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock or chk_now);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("q",      q,              e.q);
                chk("cnt",    {5'b0, cnt},    {5'b0, e.cnt});
                chk("done",   {7'b0, done},   {7'b0, e.done});
                chk("sout_r", {7'b0, sout_r}, {7'b0, e.q[0]});
                chk("sout_l", {7'b0, sout_l}, {7'b0, e.q[7]});
`ifdef PATTERN_MATCH_EN
                chk("match",  {7'b0, match},  {7'b0, (e.q == 8'h9C)});
`endif
            end
        end
    end

    always @(posedge clock) begin
        if (Resetn && en === 1'b1 && $isunknown(mode)) begin
            n_total++;
            $display("FAIL mode_x at %0t: got %b expected a known mode", $time, mode);
        end
    end

    task automatic step(input logic rn, input logic e, input logic [1:0] m, input logic sr,
                        input logic sl, input logic [7:0] dd, input logic [7:0] eq,
                        input logic [2:0] ec, input logic ed);
        @(negedge clock);
        Resetn = rn;
        en     = e;
        mode   = m;
        sin_r  = sr;
        sin_l  = sl;
        d      = dd;
        sb.push_back('{q: eq, cnt: ec, done: ed});
    endtask

    task automatic async_reset();
        @(negedge clock);
        #2;
        Resetn = 1'b0;
        sb.push_back('{q: 8'h00, cnt: 3'd0, done: 1'b0});
        -> chk_now;
        #2;
    endtask

    initial begin
        #2;
        sb.push_back('{q: 8'h00, cnt: 3'd0, done: 1'b0});
        -> chk_now;
        #2;
        step(1, 0, SR_HOLD, 0, 0, 8'h00, 8'h00, 0, 0);

        // Reach q=A5 mid-frame, then asynchronous reset; reset holds against a load.
        step(1, 1, SR_LOAD, 0, 0, 8'h4B, 8'h4B, 0, 0);
        step(1, 1, SR_SHR,  1, 0, 8'h00, 8'hA5, 1, 0);
        async_reset();
        step(0, 1, SR_LOAD, 0, 0, 8'hFF, 8'h00, 0, 0);
        step(1, 0, SR_LOAD, 0, 0, 8'hFF, 8'h00, 0, 0);

        // Load A5, 8 shifts right with sin_r=0.
        step(1, 1, SR_LOAD, 0, 0, 8'hA5, 8'hA5, 0, 0);
        step(1, 1, SR_SHR,  0, 0, 8'h00, 8'h52, 1, 0);
        step(1, 1, SR_SHR,  0, 0, 8'h00, 8'h29, 2, 0);
        step(1, 1, SR_SHR,  0, 0, 8'h00, 8'h14, 3, 0);
        step(1, 1, SR_SHR,  0, 0, 8'h00, 8'h0A, 4, 0);
        step(1, 1, SR_SHR,  0, 0, 8'h00, 8'h05, 5, 0);
        step(1, 1, SR_SHR,  0, 0, 8'h00, 8'h02, 6, 0);
        step(1, 1, SR_SHR,  0, 0, 8'h00, 8'h01, 7, 0);
        step(1, 1, SR_SHR,  0, 0, 8'h00, 8'h00, 0, 1);
        step(1, 1, SR_HOLD, 0, 0, 8'h00, 8'h00, 0, 0);

        // SIPO shift-left: 1,0,0,1,1,1,0,0 -> 9C.
        step(1, 1, SR_SHL,  0, 1, 8'h00, 8'h01, 1, 0);
        step(1, 1, SR_SHL,  0, 0, 8'h00, 8'h02, 2, 0);
        step(1, 1, SR_SHL,  0, 0, 8'h00, 8'h04, 3, 0);
        step(1, 1, SR_SHL,  0, 1, 8'h00, 8'h09, 4, 0);
        step(1, 1, SR_SHL,  0, 1, 8'h00, 8'h13, 5, 0);
        step(1, 1, SR_SHL,  0, 1, 8'h00, 8'h27, 6, 0);
        step(1, 1, SR_SHL,  0, 0, 8'h00, 8'h4E, 7, 0);
        step(1, 1, SR_SHL,  0, 0, 8'h00, 8'h9C, 0, 1);
        step(1, 1, SR_HOLD, 0, 0, 8'h00, 8'h9C, 0, 0);

        // Load F0, 3 shifts, en=0 hold, mid-frame load clears the frame.
        step(1, 1, SR_LOAD, 0, 0, 8'hF0, 8'hF0, 0, 0);
        step(1, 1, SR_SHR,  0, 0, 8'h00, 8'h78, 1, 0);
        step(1, 1, SR_SHR,  0, 0, 8'h00, 8'h3C, 2, 0);
        step(1, 1, SR_SHR,  0, 0, 8'h00, 8'h1E, 3, 0);
        step(1, 0, SR_SHR,  1, 1, 8'hFF, 8'h1E, 3, 0);
        step(1, 0, SR_SHL,  1, 1, 8'hFF, 8'h1E, 3, 0);
        step(1, 0, SR_LOAD, 1, 1, 8'hFF, 8'h1E, 3, 0);
        step(1, 0, SR_SHR,  1, 1, 8'hFF, 8'h1E, 3, 0);
        step(1, 1, SR_LOAD, 0, 0, 8'h33, 8'h33, 0, 0);
        step(1, 1, SR_SHR,  0, 0, 8'h00, 8'h19, 1, 0);
        step(1, 1, SR_SHR,  0, 0, 8'h00, 8'h0C, 2, 0);
        step(1, 1, SR_SHR,  0, 0, 8'h00, 8'h06, 3, 0);
        step(1, 1, SR_SHR,  0, 0, 8'h00, 8'h03, 4, 0);
        step(1, 1, SR_SHR,  0, 0, 8'h00, 8'h01, 5, 0);

        // 16 back-to-back shift-left of ones: done after shift 8 and 16 only.
        step(1, 1, SR_LOAD, 0, 0, 8'h00, 8'h00, 0, 0);
        step(1, 1, SR_SHL,  0, 1, 8'h00, 8'h01, 1, 0);
        step(1, 1, SR_SHL,  0, 1, 8'h00, 8'h03, 2, 0);
        step(1, 1, SR_SHL,  0, 1, 8'h00, 8'h07, 3, 0);
        step(1, 1, SR_SHL,  0, 1, 8'h00, 8'h0F, 4, 0);
        step(1, 1, SR_SHL,  0, 1, 8'h00, 8'h1F, 5, 0);
        step(1, 1, SR_SHL,  0, 1, 8'h00, 8'h3F, 6, 0);
        step(1, 1, SR_SHL,  0, 1, 8'h00, 8'h7F, 7, 0);
        step(1, 1, SR_SHL,  0, 1, 8'h00, 8'hFF, 0, 1);
        for (int unsigned i = 1; i < 8; i++)
            step(1, 1, SR_SHL, 0, 1, 8'h00, 8'hFF, 3'(i), 0);
        step(1, 1, SR_SHL,  0, 1, 8'h00, 8'hFF, 0, 1);
        step(1, 1, SR_HOLD, 0, 0, 8'h00, 8'hFF, 0, 0);

        // Direction change mid-frame still completes one frame.
        step(1, 1, SR_LOAD, 0, 0, 8'h00, 8'h00, 0, 0);
        step(1, 1, SR_SHR,  1, 0, 8'h00, 8'h80, 1, 0);
        step(1, 1, SR_SHR,  1, 0, 8'h00, 8'hC0, 2, 0);
        step(1, 1, SR_SHR,  1, 0, 8'h00, 8'hE0, 3, 0);
        step(1, 1, SR_SHR,  1, 0, 8'h00, 8'hF0, 4, 0);
        step(1, 1, SR_SHL,  0, 0, 8'h00, 8'hE0, 5, 0);
        step(1, 1, SR_SHL,  0, 0, 8'h00, 8'hC0, 6, 0);
        step(1, 1, SR_SHL,  0, 0, 8'h00, 8'h80, 7, 0);
        step(1, 1, SR_SHL,  0, 0, 8'h00, 8'h00, 0, 1);
        step(1, 1, SR_HOLD, 0, 0, 8'h00, 8'h00, 0, 0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int unsigned i = 0; i < 10 && sb.size() > 0; i++) @(posedge clock);
        #2;
        n_total++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
